// File: rtl/cheshire_boot_seq.sv
//------------------------------------------------------------------------------
// cheshire_boot_seq
//
// Purpose:
//   Sequences a single boot run of a Cheshire SoC. On start it holds the SoC
//   in reset for RstCycles cycles with the requested boot mode applied. It
//   then releases reset and counts run cycles until the SoC writes a
//   completion value into its end-of-computation scratch register. If no
//   completion arrives within TimeoutCycles run cycles, the run is forced to
//   finish and flagged as a timeout. Every output comes from a register.
//
// Parameters:
//   RstCycles       cycles the SoC reset is held after a start (1..255)
//   TimeoutCycles   maximum number of run cycles before a forced finish (>= 2)
//
// Ports:
//   clk_i            single clock
//   rst_i            asynchronous, active-high reset
//   start_i          request a boot run (honoured in IDLE and DONE)
//   abort_i          cancel the current run (honoured in RESET and RUN)
//   boot_mode_i      boot mode, latched when a start is accepted
//   eoc_valid_i      end-of-computation write strobe from the SoC
//   eoc_data_i       scratch value: bit 0 = done flag, bits 31:1 = exit code
//   soc_rst_no       active-low reset to the SoC
//   soc_boot_mode_o  boot mode driven to the SoC
//   soc_test_mode_o  test mode to the SoC, tied low
//   busy_o           high while in RESET or RUN
//   done_o           high while in DONE
//   timeout_o        the last run ended by timeout
//   exit_code_o      result of the last run
//   cycles_o         run-phase cycle count
//------------------------------------------------------------------------------
module cheshire_boot_seq #(
    parameter int unsigned RstCycles     = 16,
    parameter int unsigned TimeoutCycles = 32'd1_000_000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic [1:0]  boot_mode_i,
    input  logic        eoc_valid_i,
    input  logic [31:0] eoc_data_i,
    output logic        soc_rst_no,
    output logic [1:0]  soc_boot_mode_o,
    output logic        soc_test_mode_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        timeout_o,
    output logic [31:0] exit_code_o,
    output logic [31:0] cycles_o
);

    typedef enum logic [1:0] {
        IDLE,
        RESET,
        RUN,
        DONE
    } state_t;

    // Terminal counter values for the reset hold and for the run timeout.
    localparam logic [31:0] RstLast     = 32'(RstCycles - 1);
    localparam logic [31:0] TimeoutLast = 32'(TimeoutCycles - 1);

    state_t      r_state;
    logic [31:0] r_cnt;
    logic        r_socRstN;
    logic [1:0]  r_bootMode;
    logic        r_busy;
    logic        r_done;
    logic        r_timeout;
    logic [31:0] r_exitCode;
    logic [31:0] r_cycles;

    // A completion write only counts when the SoC sets its done flag.
    logic w_eocDone;
    assign w_eocDone = eoc_valid_i & eoc_data_i[0];

    assign soc_rst_no      = r_socRstN;
    assign soc_boot_mode_o = r_bootMode;
    assign soc_test_mode_o = 1'b0;
    assign busy_o          = r_busy;
    assign done_o          = r_done;
    assign timeout_o       = r_timeout;
    assign exit_code_o     = r_exitCode;
    assign cycles_o        = r_cycles;

    // Boot sequencer. State and all outputs are updated together so that the
    // outputs always describe the state being entered. Abort is checked
    // first in RESET and RUN so it overrides start, completion and timeout.
    // In RUN, cycles_o shadows the counter; on the finishing cycle neither
    // advances, so cycles_o keeps the index of the run cycle that ended it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_socRstN  <= 1'b0;
            r_bootMode <= 2'b00;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_timeout  <= 1'b0;
            r_exitCode <= '0;
            r_cycles   <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start_i) begin
                        r_state    <= RESET;
                        r_cnt      <= '0;
                        r_socRstN  <= 1'b0;
                        r_bootMode <= boot_mode_i;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                        r_timeout  <= 1'b0;
                        r_exitCode <= '0;
                        r_cycles   <= '0;
                    end
                end

                RESET: begin
                    if (abort_i) begin
                        r_state   <= IDLE;
                        r_socRstN <= 1'b0;
                        r_busy    <= 1'b0;
                    end else if (r_cnt == RstLast) begin
                        r_state   <= RUN;
                        r_cnt     <= '0;
                        r_socRstN <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end

                RUN: begin
                    if (abort_i) begin
                        r_state   <= IDLE;
                        r_socRstN <= 1'b0;
                        r_busy    <= 1'b0;
                    end else if (w_eocDone) begin
                        r_state    <= DONE;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_timeout  <= 1'b0;
                        r_exitCode <= {1'b0, eoc_data_i[31:1]};
                    end else if (r_cnt == TimeoutLast) begin
                        r_state    <= DONE;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_timeout  <= 1'b1;
                        r_exitCode <= 32'hFFFF_FFFF;
                    end else begin
                        r_cnt    <= r_cnt + 32'd1;
                        r_cycles <= r_cnt + 32'd1;
                    end
                end

                default: begin
                    r_state   <= IDLE;
                    r_socRstN <= 1'b0;
                    r_busy    <= 1'b0;
                    r_done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/cheshire_boot_seq.md
CHESHIRE_BOOT_SEQ -- requirements
Module: cheshire_boot_seq

Interface
REQ-001 SHALL have parameter RstCycles, default 16: cycles the SoC reset is held asserted after a start; legal range 1..255.
REQ-002 SHALL have parameter TimeoutCycles, default 32'd1_000_000: maximum run cycles before a forced finish; must be at least 2.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-004 SHALL have port rst_i, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port start_i, input, 1 bit: request a boot run; sampled on every cycle.
REQ-006 SHALL have port abort_i, input, 1 bit: cancel the current run.
REQ-007 SHALL have port boot_mode_i, input, 2 bits: requested boot mode.
REQ-008 SHALL have port eoc_valid_i, input, 1 bit: end-of-computation write strobe from the SoC scratch register.
REQ-009 SHALL have port eoc_data_i, input, 32 bits: scratch value; bit 0 = done flag, bits 31:1 = exit code.
REQ-010 SHALL have port soc_rst_no, output, 1 bit: active-low reset to the SoC.
REQ-011 SHALL have port soc_boot_mode_o, output, 2 bits: boot mode driven to the SoC.
REQ-012 SHALL have port soc_test_mode_o, output, 1 bit: tied 0.
REQ-013 SHALL have port busy_o, output, 1 bit: high in RESET or RUN.
REQ-014 SHALL have port done_o, output, 1 bit: high in DONE.
REQ-015 SHALL have port timeout_o, output, 1 bit: the last run ended by timeout.
REQ-016 SHALL have port exit_code_o, output, 32 bits: result of the last run.
REQ-017 SHALL have port cycles_o, output, 32 bits: run-phase cycle count.

Function
REQ-018 SHALL implement the FSM states IDLE, RESET, RUN and DONE; all outputs SHALL be registered.
REQ-019 IDLE: soc_rst_no=0; start_i=1 SHALL go to RESET, latch boot_mode_i into soc_boot_mode_o, and clear the counter, timeout_o, exit_code_o and cycles_o.
REQ-020 RESET: soc_rst_no=0 for exactly RstCycles cycles, counted from the first cycle in RESET; then the FSM SHALL go to RUN and clear the counter.
REQ-021 soc_boot_mode_o SHALL stay stable from the latch until the next start; changes on boot_mode_i at any other time are ignored.
REQ-022 RUN: soc_rst_no=1 and the counter SHALL increment every cycle; cycles_o equals the counter.
REQ-023 RUN with eoc_valid_i=1 and eoc_data_i[0]=1 SHALL go to DONE, set exit_code_o={1'b0, eoc_data_i[31:1]} and timeout_o=0.
REQ-024 RUN with eoc_valid_i=1 and eoc_data_i[0]=0 SHALL be ignored.
REQ-025 RUN when the counter equals TimeoutCycles-1 and there is no qualifying eoc SHALL go to DONE, set timeout_o=1 and exit_code_o=32'hFFFF_FFFF.
REQ-026 A qualifying eoc in the same cycle as the timeout SHALL win: timeout_o=0.
REQ-027 DONE: soc_rst_no stays 1 and cycles_o is frozen; start_i SHALL restart at RESET per REQ-019.
REQ-028 abort_i in RESET or RUN SHALL go to IDLE next cycle with soc_rst_no=0; outputs keep their values; abort_i is ignored in IDLE and DONE.
REQ-029 abort_i SHALL have priority over start_i, eoc and timeout in the same cycle.
REQ-030 start_i in RESET or RUN SHALL be ignored.
REQ-031 The counter SHALL be 32 bits wide and SHALL never wrap, because the timeout bounds it.

Reset
REQ-032 While rst_i=1 (asynchronous), the block SHALL hold: state=IDLE, soc_rst_no=0, soc_boot_mode_o=0, soc_test_mode_o=0, busy_o=0, done_o=0, timeout_o=0, exit_code_o=0, cycles_o=0, counter=0.
REQ-033 rst_i asserted mid-run SHALL force the REQ-032 values immediately, without waiting for a clock edge.
REQ-034 After rst_i deasserts, the block SHALL be in IDLE and wait for start_i.

Verification
REQ-035 Scenario: start_i pulse with boot_mode_i=2'b01, RstCycles=16 -> soc_rst_no low exactly 16 cycles, then high; soc_boot_mode_o=01 throughout; busy_o=1.
REQ-036 Scenario: in RUN, eoc_valid_i with eoc_data_i=32'h0000_0001 at run cycle 100 -> done_o=1, exit_code_o=0, timeout_o=0, cycles_o=100.
REQ-037 Scenario: TimeoutCycles=50, no eoc -> DONE after 50 run cycles with timeout_o=1 and exit_code_o=FFFF_FFFF; eoc_data_i=32'h0000_0007 at cycle 49 instead -> exit_code_o=3 and timeout_o=0.
REQ-038 Scenario: eoc_valid_i with eoc_data_i=32'h0000_0006 -> ignored, FSM stays in RUN; start_i pulsed during RUN -> no effect.
REQ-039 Scenario: abort_i together with start_i in RUN -> IDLE with soc_rst_no=0; a later start re-enters RESET with cycles_o cleared.
REQ-040 Scenario: rst_i pulse mid-RUN, between clock edges -> soc_rst_no falls immediately and all outputs take the REQ-032 values.
